// File: rtl/l2cache_pkg.sv
// Shared types and constants for the L2 cache controller.
package l2cache_pkg;

  localparam int L2_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    TAG_CHECK,
    WRITEBACK,
    FILL
  } l2_state_t;

endpackage

// File: rtl/l2cache_control_if.sv
// Upstream request/response and physical memory handshake bundle.
interface l2cache_control_if;

  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;

  modport slave (
    input  mem_read, mem_write, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );

  modport master (
    output mem_read, mem_write, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );

endinterface

// File: rtl/l2_perf_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module l2_perf_counter
  import l2cache_pkg::*;
#(
  parameter int WIDTH = L2_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count one event per cycle while below the saturation value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/l2cache_control.sv
// Two-way L2 cache controller: tag check, dirty writeback and line fill
// sequencing, plus hit/miss/writeback performance counters.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for an upstream read or write request
// TAG_CHECK | compare tags; hit completes, miss starts memory traffic
// WRITEBACK | writing the dirty victim line back to memory
// FILL      | reading the missing line from memory into way LRU
module l2cache_control
  import l2cache_pkg::*;
#(
  parameter int CNT_WIDTH = L2_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  l2cache_control_if.slave     bus,
  input  logic                 hit0,
  input  logic                 hit1,
  input  logic                 dirty_eviction,
  input  logic                 LRU,
  output logic                 WE0,
  output logic                 WE1,
  output logic                 ld_dirty0,
  output logic                 ld_dirty1,
  output logic                 ld_valid0,
  output logic                 ld_valid1,
  output logic                 clear_dirty0,
  output logic                 clear_dirty1,
  output logic                 mem_b_sel,
  output logic                 eviction_addr_sel,
  output logic                 mem_addr_sel,
  output logic                 load_lru,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  l2_state_t state, state_nxt;
  logic      post_fill;
  logic      req, hit;
  logic      mem_resp, pmem_read, pmem_write;
  logic      hit_inc, miss_inc, wb_inc;

  assign req = bus.mem_read | bus.mem_write;
  assign hit = hit0 | hit1;

  assign bus.mem_resp   = mem_resp;
  assign bus.pmem_read  = pmem_read;
  assign bus.pmem_write = pmem_write;

  // State register; post_fill marks the re-check right after a fill so it is not counted as a hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      post_fill <= 1'b0;
    end else begin
      state     <= state_nxt;
      post_fill <= (state == FILL) && bus.pmem_resp;
    end
  end

  // Next-state and combinational datapath controls.
  always_comb begin
    state_nxt         = state;
    mem_resp          = 1'b0;
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    WE0               = 1'b0;
    WE1               = 1'b0;
    ld_dirty0         = 1'b0;
    ld_dirty1         = 1'b0;
    ld_valid0         = 1'b0;
    ld_valid1         = 1'b0;
    clear_dirty0      = 1'b0;
    clear_dirty1      = 1'b0;
    mem_b_sel         = 1'b0;
    eviction_addr_sel = 1'b0;
    mem_addr_sel      = 1'b0;
    load_lru          = 1'b0;
    hit_inc           = 1'b0;
    miss_inc          = 1'b0;
    wb_inc            = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) state_nxt = TAG_CHECK;
      end
      TAG_CHECK: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (hit) begin
          mem_resp  = 1'b1;
          load_lru  = 1'b1;
          hit_inc   = !post_fill;
          state_nxt = IDLE;
          // A simultaneous read and write is serviced as a write; way 0 wins a double hit.
          if (bus.mem_write) begin
            if (hit0) begin
              WE0       = 1'b1;
              ld_dirty0 = 1'b1;
            end else begin
              WE1       = 1'b1;
              ld_dirty1 = 1'b1;
            end
          end
        end else begin
          miss_inc  = 1'b1;
          state_nxt = dirty_eviction ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write        = 1'b1;
        mem_addr_sel      = 1'b1;
        eviction_addr_sel = LRU;
        if (bus.pmem_resp) begin
          wb_inc    = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          mem_b_sel = 1'b1;
          state_nxt = TAG_CHECK;
          if (LRU) begin
            WE1          = 1'b1;
            ld_valid1    = 1'b1;
            ld_dirty1    = 1'b1;
            clear_dirty1 = 1'b1;
          end else begin
            WE0          = 1'b1;
            ld_valid0    = 1'b1;
            ld_dirty0    = 1'b1;
            clear_dirty0 = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  l2_perf_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk(clk), .reset(reset), .inc(hit_inc), .count(hit_count)
  );

  l2_perf_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk(clk), .reset(reset), .inc(miss_inc), .count(miss_count)
  );

  l2_perf_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk(clk), .reset(reset), .inc(wb_inc), .count(wb_count)
  );

endmodule

// File: tb/tb_l2cache_control.sv
// Directed bench for the L2 cache controller: hits, misses, writeback,
// reset mid-fill and counter saturation, with hand-derived expectations.
module tb_l2cache_control;
  import l2cache_pkg::*;

  localparam int CW = 4;

  localparam logic [14:0] C_RESP = 15'h4000;
  localparam logic [14:0] C_PRD  = 15'h2000;
  localparam logic [14:0] C_PWR  = 15'h1000;
  localparam logic [14:0] C_WE0  = 15'h0800;
  localparam logic [14:0] C_WE1  = 15'h0400;
  localparam logic [14:0] C_LDD0 = 15'h0200;
  localparam logic [14:0] C_LDD1 = 15'h0100;
  localparam logic [14:0] C_LDV0 = 15'h0080;
  localparam logic [14:0] C_LDV1 = 15'h0040;
  localparam logic [14:0] C_CLD0 = 15'h0020;
  localparam logic [14:0] C_CLD1 = 15'h0010;
  localparam logic [14:0] C_MBS  = 15'h0008;
  localparam logic [14:0] C_EAS  = 15'h0004;
  localparam logic [14:0] C_MAS  = 15'h0002;
  localparam logic [14:0] C_LRU  = 15'h0001;
  localparam logic [14:0] C_NONE = 15'h0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hit0 = 1'b0, hit1 = 1'b0, dirty_eviction = 1'b0, LRU = 1'b0;
  logic WE0, WE1, ld_dirty0, ld_dirty1, ld_valid0, ld_valid1;
  logic clear_dirty0, clear_dirty1, mem_b_sel, eviction_addr_sel, mem_addr_sel, load_lru;
  logic [CW-1:0] hit_count, miss_count, wb_count;
  logic [14:0] ctl;

  int n_cmp = 0;
  int n_bad = 0;

  l2cache_control_if bus ();

  always #5 clk = ~clk;

  l2cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .hit0(hit0), .hit1(hit1), .dirty_eviction(dirty_eviction), .LRU(LRU),
    .WE0(WE0), .WE1(WE1), .ld_dirty0(ld_dirty0), .ld_dirty1(ld_dirty1),
    .ld_valid0(ld_valid0), .ld_valid1(ld_valid1),
    .clear_dirty0(clear_dirty0), .clear_dirty1(clear_dirty1),
    .mem_b_sel(mem_b_sel), .eviction_addr_sel(eviction_addr_sel),
    .mem_addr_sel(mem_addr_sel), .load_lru(load_lru),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  assign ctl = {bus.mem_resp, bus.pmem_read, bus.pmem_write, WE0, WE1,
                ld_dirty0, ld_dirty1, ld_valid0, ld_valid1,
                clear_dirty0, clear_dirty1, mem_b_sel, eviction_addr_sel,
                mem_addr_sel, load_lru};

  task automatic chk_ctl(input string tag, input logic [14:0] exp);
    n_cmp++;
    assert (ctl === exp) else begin
      n_bad++;
      $error("FAIL %s: observed ctl=%b expected ctl=%b", tag, ctl, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Exclusivity invariants sampled mid-cycle whenever out of reset.
  always @(negedge clk) begin
    if (reset) begin
      n_cmp++;
      assert (!(bus.pmem_read && bus.pmem_write) && !(WE0 && WE1)) else begin
        n_bad++;
        $error("FAIL exclusivity: observed pr=%b pw=%b we0=%b we1=%b expected no pair high",
               bus.pmem_read, bus.pmem_write, WE0, WE1);
      end
    end
  end

  initial begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.pmem_resp = 1'b0;

    // Reset state
    #12;
    chk_ctl("reset_ctl", C_NONE);
    chk_cnt("reset_hit", hit_count, 4'd0);
    chk_cnt("reset_miss", miss_count, 4'd0);
    chk_cnt("reset_wb", wb_count, 4'd0);
    #1 reset = 1'b1;
    step();
    chk_ctl("idle_quiet", C_NONE);

    // Read hit on way 0
    bus.mem_read = 1'b1; hit0 = 1'b1;
    #1 chk_ctl("idle_req_no_out", C_NONE);
    step();
    chk_ctl("rd_hit_c1", C_RESP | C_LRU);
    step();
    bus.mem_read = 1'b0; hit0 = 1'b0;
    #1 chk_ctl("rd_hit_done", C_NONE);
    chk_cnt("rd_hit_count", hit_count, 4'd1);

    // Write hit on way 1
    bus.mem_write = 1'b1; hit1 = 1'b1;
    step();
    chk_ctl("wr_hit_c1", C_RESP | C_WE1 | C_LDD1 | C_LRU);
    step();
    bus.mem_write = 1'b0; hit1 = 1'b0;
    #1 chk_cnt("wr_hit_count", hit_count, 4'd2);

    // Read and write together act as a write
    bus.mem_read = 1'b1; bus.mem_write = 1'b1; hit0 = 1'b1;
    step();
    chk_ctl("rw_as_write", C_RESP | C_WE0 | C_LDD0 | C_LRU);
    step();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; hit0 = 1'b0;
    #1 chk_cnt("rw_hit_count", hit_count, 4'd3);

    // Clean read miss, LRU=0, pmem_resp on 5th fill cycle
    bus.mem_read = 1'b1; LRU = 1'b0; dirty_eviction = 1'b0;
    step();
    chk_ctl("miss_tag_check", C_NONE);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_ctl("fill_wait", C_PRD);
    end
    step();
    bus.pmem_resp = 1'b1; hit0 = 1'b1;
    #1 chk_ctl("fill_write_way0", C_PRD | C_WE0 | C_LDV0 | C_MBS | C_LDD0 | C_CLD0);
    step();
    bus.pmem_resp = 1'b0;
    #1 chk_ctl("post_fill_resp", C_RESP | C_LRU);
    step();
    bus.mem_read = 1'b0; hit0 = 1'b0;
    #1 chk_cnt("miss_count_1", miss_count, 4'd1);
    chk_cnt("post_fill_no_hit", hit_count, 4'd3);

    // Request withdrawn in TAG_CHECK
    bus.mem_read = 1'b1;
    step();
    bus.mem_read = 1'b0;
    #1 chk_ctl("withdraw_tc", C_NONE);
    step();
    chk_ctl("withdraw_idle", C_NONE);
    chk_cnt("withdraw_miss", miss_count, 4'd1);

    // Dirty write miss, LRU=1
    bus.mem_write = 1'b1; dirty_eviction = 1'b1; LRU = 1'b1;
    step();
    step();
    chk_ctl("wb_c1", C_PWR | C_MAS | C_EAS);
    step();
    chk_ctl("wb_c2", C_PWR | C_MAS | C_EAS);
    bus.pmem_resp = 1'b1;
    step();
    bus.pmem_resp = 1'b0; dirty_eviction = 1'b0;
    #1 chk_ctl("dirty_fill_wait", C_PRD);
    chk_cnt("wb_count_1", wb_count, 4'd1);
    step();
    bus.pmem_resp = 1'b1; hit1 = 1'b1;
    #1 chk_ctl("fill_write_way1", C_PRD | C_WE1 | C_LDV1 | C_MBS | C_LDD1 | C_CLD1);
    step();
    bus.pmem_resp = 1'b0;
    #1 chk_ctl("dirty_post_fill_wr", C_RESP | C_WE1 | C_LDD1 | C_LRU);
    step();
    bus.mem_write = 1'b0; hit1 = 1'b0; LRU = 1'b0;
    #1 chk_cnt("dirty_miss_count", miss_count, 4'd2);
    chk_cnt("dirty_hit_count", hit_count, 4'd3);

    // Asynchronous reset in the middle of a fill
    bus.mem_read = 1'b1;
    step();
    step();
    chk_ctl("pre_reset_fill", C_PRD);
    #1 reset = 1'b0;
    #1 chk_ctl("async_reset_ctl", C_NONE);
    chk_cnt("async_reset_hit", hit_count, 4'd0);
    chk_cnt("async_reset_miss", miss_count, 4'd0);
    chk_cnt("async_reset_wb", wb_count, 4'd0);
    bus.mem_read = 1'b0; bus.pmem_resp = 1'b1;
    #2 reset = 1'b1;
    step();
    chk_ctl("stale_resp_ignored", C_NONE);
    bus.pmem_resp = 1'b0;

    // Normal operation after reset, then saturation
    bus.mem_read = 1'b1; hit0 = 1'b1;
    step();
    chk_ctl("after_reset_hit", C_RESP | C_LRU);
    step();
    chk_cnt("after_reset_count", hit_count, 4'd1);
    for (int i = 0; i < 13; i++) begin
      step();
      step();
    end
    chk_cnt("hit_count_14", hit_count, 4'd14);
    for (int i = 0; i < 3; i++) begin
      step();
      step();
    end
    chk_cnt("hit_count_sat", hit_count, 4'hF);
    bus.mem_read = 1'b0; hit0 = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
